uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Queues bytes written by the CPU for UART transmission and sequences them into the UART transmitter one at a time. It generates the single-cycle tx_enable launch pulse and tracks the transmitter's idle/busy status across the clock boundary. It sits in the peripheral block between the bus write decode (push) and the UART instance (tx_data/tx_enable/tx_status), so software never has to poll for tx_status before each byte.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, >= 2
AW, 3, log2(DEPTH); pointer width
ACK_TIMEOUT, 255, max clk cycles in WAIT_BUSY before the byte is abandoned

Ports:
clk  in  1  peripheral clock; all logic on posedge
reset  in  1  synchronous, active-high reset
push  in  1  enqueue push_data this cycle
push_data  in  8  byte to enqueue
flush  in  1  discard all queued (not yet launched) bytes
clr_err  in  1  clears overflow and timeout sticky flags
tx_status  in  1  UART transmitter status from sysclk domain; 1 = idle, 0 = sending; asynchronous
tx_data  out  8  byte presented to UART, registered
tx_enable  out  1  one-cycle launch pulse to UART, registered
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  AW+1  bytes queued, 0..DEPTH
busy  out  1  FSM not in IDLE
overflow  out  1  sticky: push dropped because FIFO full
timeout  out  1  sticky: UART never went busy after launch

Behaviour:
- Reset (sync, active-high): pointers = 0, count = 0, state IDLE, tx_data = 0x00, tx_enable = 0, overflow = 0, timeout = 0, timer = 0, both synchronizer flops = 0. Outputs after reset: empty = 1, full = 0, busy = 0.
- Synchronizer: tx_status passes through 2 flops to produce st_s; latency 2 clk. Because the flops reset to 0, no launch occurs until the UART has been seen idle.
- FIFO: circular buffer with AW-bit read/write pointers that wrap DEPTH-1 -> 0. count is maintained explicitly.
- Push is accepted iff full == 0, using the registered full at the start of the cycle. A push while full is dropped even if a pop occurs in the same cycle, and sets overflow. A push and a pop in the same cycle leave count unchanged.
- flush: next cycle count = 0 and rd_ptr = wr_ptr = 0. flush has priority over a push and a pop in the same cycle; the pushed byte is discarded and overflow is not set. flush does not affect the FSM or an in-flight byte.
- clr_err clears overflow and timeout next cycle. A set event in the same cycle wins, so the flag stays 1.
- FSM states and transitions:
  - IDLE: if !empty && st_s == 1, pop head into tx_data and go to START. The first launch after a push into an empty FIFO is at the earliest the cycle after the push.
  - START: tx_enable = 1 for exactly this cycle; timer = 0; go to WAIT_BUSY.
  - WAIT_BUSY: if st_s == 0, go to WAIT_DONE. Otherwise timer++. When timer reaches ACK_TIMEOUT, set timeout and go to IDLE; the byte is abandoned and not retried.
  - WAIT_DONE: if st_s == 1, go to IDLE.
- tx_enable is high only in START. It is never high in two consecutive cycles.
- tx_data holds its value from the pop until the next pop.
- busy = (state != IDLE).
- Minimum spacing between launches is START + WAIT_BUSY + WAIT_DONE + IDLE, i.e. at least 4 clk plus the UART busy time.
- Reset asserted mid-operation (any state) aborts immediately: next cycle all values are as after reset, and the queue contents are lost.

Test Plan:
- Hold tx_status = 1; push 0x41, 0x42, 0x43 on consecutive cycles; UART model drops tx_status for 20 cycles after each tx_enable -> exactly 3 single-cycle tx_enable pulses with tx_data = 0x41, 0x42, 0x43 in order; count peaks at 3 (or 2 if the first pop overlaps); final empty = 1, busy = 0.
- Hold tx_status = 0; push 9 bytes -> after 8 pushes full = 1, count = 8; 9th push gives overflow = 1, count stays 8. Pulse clr_err -> overflow = 0. Raise tx_status -> the first 8 bytes are sent in order.
- After a launch, UART model keeps tx_status = 1 -> after 255 cycles in WAIT_BUSY, timeout = 1 and state returns to IDLE. With 2 more bytes queued, the next byte is launched 1 cycle later.
- Queue 5 bytes; assert flush during WAIT_DONE of byte 1 -> next cycle count = 0, empty = 1; byte 1 completes; no further tx_enable pulses.
- Assert push (0x55) and flush in the same cycle with count = 2 -> count = 0 next cycle; no tx_enable; overflow = 0.
- Assert reset in WAIT_DONE with 3 queued -> next cycle tx_enable = 0, busy = 0, count = 0. After reset release, then push 0x7E with tx_status = 1 -> launch occurs only after st_s reaches 1 (>= 2 cycles after release).

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Byte queue between the CPU write decode and a UART transmitter. Bytes are
// buffered in a small circular FIFO and launched one at a time. Each launch
// is a single-cycle tx_enable pulse. The scheduler then follows the
// transmitter's idle/busy status, which arrives from another clock domain,
// so that software never has to poll tx_status before writing a byte.
//
// Handshake: push/push_data is a valid/ready pair. The ready side is !full,
// sampled from the registered count at the start of the cycle. A byte
// transfers only in a cycle where push && !full. A push while full is not
// stalled. It is dropped and recorded in the sticky overflow flag.

module uart_tx_scheduler #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          flush,
    input  logic          clr_err,
    input  logic          tx_status,
    output logic [7:0]    tx_data,
    output logic          tx_enable,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          overflow,
    output logic          timeout
);

    // Timer is wide enough to hold ACK_TIMEOUT. WAIT_BUSY gives up on the
    // cycle in which the timer holds ACK_TIMEOUT-1. That cycle is the
    // ACK_TIMEOUT-th cycle spent waiting.
    localparam int             TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [AW:0]    DEPTH_C    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Scheduler state. The state register is kept under a plain name so
    // checkers can bind to it; busy is its externally visible summary.
    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;

    // Synchronized transmitter status. It resets to 0 (busy), so nothing
    // launches until the UART has been seen idle through both flops.
    logic            st_meta;
    logic            st_s;

    // FIFO storage and pointers.
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      head;

    // Per-cycle events.
    logic            push_acc;
    logic            pop;
    logic            overflow_set;
    logic            timeout_set;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    assign head  = mem[rd_ptr];

    // Acceptance uses the registered full. A simultaneous pop does not free
    // a slot for this cycle's push. A flush discards the pushed byte and
    // does not count it as an overflow.
    assign push_acc     = push && !full && !flush;
    assign overflow_set = push && full && !flush;

    // Two-flop synchronizer for the asynchronous transmitter status.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_meta <= 1'b0;
            st_s    <= 1'b0;
        end else begin
            st_meta <= tx_status;
            st_s    <= st_meta;
        end
    end

    // Byte storage. It is written only on an accepted push and needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and the explicit occupancy count. A flush empties the queue
    // but leaves any byte already handed to the transmitter alone.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. A set event in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end else if (clr_err) begin
                timeout <= 1'b0;
            end
        end
    end

    // Scheduler registers. The launched byte is captured on the pop. The
    // launch pulse is registered, so it is high exactly while in START.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            tx_data   <= 8'h00;
            tx_enable <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            tx_enable <= (state_next == START);
            if (pop) begin
                tx_data <= head;
            end
        end
    end

    // Scheduler next state. It pops when the UART is idle, pulses START,
    // waits for the UART to go busy (or gives up), then waits for it to go idle.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && st_s) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                timer_next = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!st_s) begin
                    state_next = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    // The UART never acknowledged; drop this byte and move on.
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (st_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART status model.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [7:0]  push_data;
    logic        flush;
    logic        clr_err;
    logic        tx_status;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        busy;
    logic        overflow;
    logic        timeout;

    // UART model: it goes busy for 20 cycles after each sampled tx_enable.
    // uart_auto selects the model; otherwise man_status drives tx_status.
    logic        uart_auto  = 1'b0;
    logic        man_status = 1'b1;
    int          busy_cnt   = 0;
    logic        model_status;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          peak     = 0;
    int          cyc      = 0;
    logic        prev_en     = 1'b0;
    logic        consec_seen = 1'b0;
    logic [7:0]  got_q[$];
    int          launch_t[$];
    int          base;

    assign model_status = (busy_cnt == 0);
    assign tx_status    = uart_auto ? model_status : man_status;

    uart_tx_scheduler #(.DEPTH(8), .AW(3), .ACK_TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .flush     (flush),
        .clr_err   (clr_err),
        .tx_status (tx_status),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // UART busy model.
    always @(posedge clk) begin
        if (tx_enable) begin
            busy_cnt <= 20;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Launch monitor: it records every launched byte and its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_enable) begin
            got_q.push_back(tx_data);
            launch_t.push_back(cyc);
        end
        if (tx_enable && prev_en) begin
            consec_seen <= 1'b1;
        end
        prev_en <= tx_enable;
    end

    // Global time limit.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (int'(count) > peak) peak = int'(count);
        end
    endtask

    task automatic wait_enable(input string tag, input int max);
        int n = 0;
        while (tx_enable !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (!(empty === 1'b1 && busy === 1'b0) && n < max) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        push_data = 8'h00;
        flush     = 1'b0;
        clr_err   = 1'b0;
        tick(3);

        // Reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;

        // Test 1: three bytes with a responsive UART
        uart_auto = 1'b1;
        tick(4);
        peak = 0;
        base = got_q.size();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_data = 8'h41 + 8'(i);
            tick(1);
        end
        push = 1'b0;
        wait_idle("t1_drain", 500);
        check("t1_launches", got_q.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_byte", got_q[base + i], 8'h41 + 8'(i));
        end
        check("t1_peak", peak, 2);
        check("t1_empty", empty, 1);
        check("t1_busy", busy, 0);

        // Test 2: fill, overflow, clear, then drain in order
        uart_auto = 1'b0;
        man_status = 1'b0;
        tick(3);
        base = got_q.size();
        for (int i = 0; i < 8; i++) begin
            push = 1'b1;
            push_data = 8'h10 + 8'(i);
            tick(1);
        end
        check("t2_count8", count, 8);
        check("t2_full", full, 1);
        check("t2_no_ovf_yet", overflow, 0);
        push_data = 8'h18;
        tick(1);
        push = 1'b0;
        check("t2_overflow", overflow, 1);
        check("t2_count_hold", count, 8);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t2_ovf_cleared", overflow, 0);
        uart_auto = 1'b1;
        wait_idle("t2_drain", 1000);
        check("t2_launches", got_q.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_byte", got_q[base + i], 8'h10 + 8'(i));
        end

        // Test 3: UART never acknowledges, so the launch times out
        uart_auto = 1'b0;
        man_status = 1'b1;
        base = got_q.size();
        push = 1'b1;
        push_data = 8'h21;
        tick(1);
        push = 1'b0;
        wait_enable("t3_first_launch", 20);
        check("t3_first_byte", tx_data, 8'h21);
        push = 1'b1;
        push_data = 8'h22;
        tick(1);
        push_data = 8'h23;
        tick(1);
        push = 1'b0;
        tick(253);
        check("t3_timeout_early", timeout, 0);
        check("t3_busy_waiting", busy, 1);
        tick(1);
        check("t3_timeout_set", timeout, 1);
        check("t3_back_idle", busy, 0);
        tick(1);
        check("t3_next_launch", tx_enable, 1);
        check("t3_next_byte", tx_data, 8'h22);
        uart_auto = 1'b1;
        wait_idle("t3_drain", 500);
        check("t3_launches", got_q.size() - base, 3);
        check("t3_gap", launch_t[base + 1] - launch_t[base], 257);
        check("t3_byte3", got_q[base + 2], 8'h23);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t3_timeout_cleared", timeout, 0);

        // Test 4: flush while the first byte is in WAIT_DONE
        base = got_q.size();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1;
            push_data = 8'h31 + 8'(i);
            tick(1);
        end
        push = 1'b0;
        tick(4);
        check("t4_count_before", count, 4);
        check("t4_busy_before", busy, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_count_flushed", count, 0);
        check("t4_empty_flushed", empty, 1);
        check("t4_inflight_busy", busy, 1);
        wait_idle("t4_drain", 200);
        tick(10);
        check("t4_launches", got_q.size() - base, 1);
        check("t4_byte", got_q[base], 8'h31);

        // Test 5: push and flush in the same cycle
        uart_auto = 1'b0;
        man_status = 1'b0;
        tick(3);
        base = got_q.size();
        push = 1'b1;
        push_data = 8'h51;
        tick(1);
        push_data = 8'h52;
        tick(1);
        check("t5_count2", count, 2);
        push_data = 8'h55;
        flush = 1'b1;
        tick(1);
        push = 1'b0;
        flush = 1'b0;
        check("t5_count0", count, 0);
        check("t5_empty", empty, 1);
        check("t5_no_overflow", overflow, 0);
        man_status = 1'b1;
        tick(8);
        check("t5_no_launch", got_q.size() - base, 0);
        check("t5_idle", busy, 0);

        // Test 6: reset in WAIT_DONE, then relaunch through the synchronizer
        uart_auto = 1'b1;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            push_data = 8'h61 + 8'(i);
            tick(1);
        end
        push = 1'b0;
        tick(4);
        check("t6_count3", count, 3);
        check("t6_busy", busy, 1);
        uart_auto = 1'b0;
        man_status = 1'b1;
        reset = 1'b1;
        tick(1);
        check("t6_rst_tx_enable", tx_enable, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        push = 1'b1;
        push_data = 8'h7E;
        tick(1);
        push = 1'b0;
        check("t6_count1", count, 1);
        check("t6_no_launch_1", tx_enable, 0);
        tick(1);
        check("t6_no_launch_2", tx_enable, 0);
        check("t6_still_idle", busy, 0);
        tick(1);
        check("t6_launch", tx_enable, 1);
        check("t6_launch_byte", tx_data, 8'h7E);
        uart_auto = 1'b1;
        wait_idle("t6_drain", 200);

        check("no_back_to_back_enable", consec_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
